// File: rtl/usb_pkg.sv
// Shared USB receive-path types: line-state classification, receiver FSM states
// and the bit-stuffing run limit.
package usb_pkg;

    typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} rx_state_t;

    localparam int STUFF_LIMIT = 6;

    function automatic line_state_t classify(input logic dp, input logic dm);
        case ({dp, dm})
            2'b10:   return J;
            2'b01:   return K;
            2'b00:   return SE0;
            default: return SE1;
        endcase
    endfunction

endpackage

// File: rtl/bit_unstuffer.sv
// Tracks the run of decoded 1s and flags the bit after a full run as either a
// stuffed 0 to drop or a stuffing violation.
module bit_unstuffer
    import usb_pkg::*;
(
    input  logic clk,
    input  logic nRST,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_drop,
    output logic o_viol
);

    logic [2:0] r_ones_cnt;
    logic       w_full;

    assign w_full = (r_ones_cnt == 3'(STUFF_LIMIT));
    assign o_drop = w_full & ~i_bit;
    assign o_viol = w_full & i_bit;

    // The SYNC's terminating 1 already counts toward the first run.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            r_ones_cnt <= '0;
        else if (i_clr)
            r_ones_cnt <= '0;
        else if (i_load)
            r_ones_cnt <= 3'd1;
        else if (i_shift)
            r_ones_cnt <= (w_full || !i_bit) ? 3'd0 : r_ones_cnt + 3'd1;
    end

endmodule

// File: rtl/nrzi_decoder.sv
// USB receive bit layer: SYNC detection, NRZI decode, unstuffing and EOP detection
// on strobed line samples, producing a registered decoded-bit stream.
module nrzi_decoder
    import usb_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int ERR_IDLE_BITS  = 8
) (
    input  logic clk,
    input  logic nRST,
    input  logic i_rx_enable,
    input  logic i_bit_strobe,
    input  logic i_dp,
    input  logic i_dm,
    output logic o_dec_bit,
    output logic o_dec_valid,
    output logic o_sync_found,
    output logic o_eop_found,
    output logic o_stuff_err,
    output logic o_rx_active
);

    localparam int IDLE_W = $clog2(ERR_IDLE_BITS + 1);

    rx_state_t         r_state, w_state_nxt;
    line_state_t       r_prev_line, w_prev_nxt, w_line;
    logic [2:0]        r_zero_cnt, w_zero_nxt;
    logic [1:0]        r_se0_cnt, w_se0_nxt;
    logic [IDLE_W-1:0] r_idle_cnt, w_idle_nxt;
    logic              r_last_se0, w_last_se0_nxt;
    logic              w_is_jk, w_bit, w_drop, w_viol, w_shift;
    logic              w_dec_bit, w_dec_valid, w_sync, w_eop, w_err, w_rx_active_nxt;

    assign w_line  = classify(i_dp, i_dm);
    assign w_is_jk = (w_line == J) || (w_line == K);
    assign w_bit   = (w_line == r_prev_line);
    assign w_shift = i_rx_enable && i_bit_strobe && (r_state == DATA) && w_is_jk;

    bit_unstuffer u_unstuff (
        .clk     (clk),
        .nRST    (nRST),
        .i_clr   (!i_rx_enable),
        .i_load  (w_sync),
        .i_shift (w_shift),
        .i_bit   (w_bit),
        .o_drop  (w_drop),
        .o_viol  (w_viol)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_prev_line  <= J;
            r_zero_cnt   <= '0;
            r_se0_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_last_se0   <= 1'b0;
            o_dec_bit    <= 1'b0;
            o_dec_valid  <= 1'b0;
            o_sync_found <= 1'b0;
            o_eop_found  <= 1'b0;
            o_stuff_err  <= 1'b0;
            o_rx_active  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_line  <= w_prev_nxt;
            r_zero_cnt   <= w_zero_nxt;
            r_se0_cnt    <= w_se0_nxt;
            r_idle_cnt   <= w_idle_nxt;
            r_last_se0   <= w_last_se0_nxt;
            o_dec_bit    <= w_dec_bit;
            o_dec_valid  <= w_dec_valid;
            o_sync_found <= w_sync;
            o_eop_found  <= w_eop;
            o_stuff_err  <= w_err;
            o_rx_active  <= w_rx_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_prev_nxt     = r_prev_line;
        w_zero_nxt     = r_zero_cnt;
        w_se0_nxt      = r_se0_cnt;
        w_idle_nxt     = r_idle_cnt;
        w_last_se0_nxt = r_last_se0;
        if (!i_rx_enable) begin
            w_state_nxt    = IDLE;
            w_prev_nxt     = J;
            w_zero_nxt     = '0;
            w_se0_nxt      = '0;
            w_idle_nxt     = '0;
            w_last_se0_nxt = 1'b0;
        end else if (i_bit_strobe) begin
            if (w_is_jk)
                w_prev_nxt = w_line;
            case (r_state)
                IDLE: if (w_line == K) begin
                    w_zero_nxt  = 3'd1;
                    w_state_nxt = SYNC;
                end
                SYNC: begin
                    if (!w_is_jk)
                        w_state_nxt = IDLE;
                    else if (!w_bit)
                        w_zero_nxt = (r_zero_cnt == 3'd7) ? 3'd7 : r_zero_cnt + 3'd1;
                    else
                        w_state_nxt = (int'(r_zero_cnt) >= SYNC_MIN_ZEROS) ? DATA : IDLE;
                end
                DATA: begin
                    if (w_line == SE0) begin
                        w_se0_nxt   = 2'd1;
                        w_state_nxt = EOP;
                    end else if (w_line == SE1 || w_viol)
                        w_state_nxt = ERR;
                end
                EOP: begin
                    if (w_line == SE0) begin
                        if (r_se0_cnt == 2'd3)
                            w_state_nxt = ERR;
                        else
                            w_se0_nxt = r_se0_cnt + 2'd1;
                    end else
                        w_state_nxt = (w_line == J) ? IDLE : ERR;
                end
                ERR: begin
                    if (w_line == J) begin
                        w_idle_nxt = r_idle_cnt + 1'b1;
                        if (r_last_se0 || int'(r_idle_cnt) + 1 >= ERR_IDLE_BITS)
                            w_state_nxt = IDLE;
                    end else
                        w_idle_nxt = '0;
                    w_last_se0_nxt = (w_line == SE0);
                end
                default: w_state_nxt = IDLE;
            endcase
            // The sample that caused the error may itself be the SE0 a J can follow.
            if (w_state_nxt == ERR && r_state != ERR) begin
                w_idle_nxt     = '0;
                w_last_se0_nxt = (w_line == SE0);
            end
        end
    end

    always_comb begin
        w_dec_bit       = 1'b0;
        w_dec_valid     = 1'b0;
        w_sync          = 1'b0;
        w_eop           = 1'b0;
        w_err           = 1'b0;
        w_rx_active_nxt = i_rx_enable ? o_rx_active : 1'b0;
        if (i_rx_enable && i_bit_strobe) begin
            w_dec_valid = (r_state == DATA) && w_is_jk && !w_drop && !w_viol;
            w_dec_bit   = w_dec_valid && w_bit;
            w_sync      = (r_state == SYNC) && (w_state_nxt == DATA);
            w_eop       = (r_state == EOP) && (w_state_nxt == IDLE);
            w_err       = (r_state != ERR) && (w_state_nxt == ERR);
            if (w_sync)
                w_rx_active_nxt = 1'b1;
            else if (w_eop || w_err)
                w_rx_active_nxt = 1'b0;
        end
    end

endmodule

// File: doc/nrzi_decoder.md
# nrzi_decoder

Receive-side bit layer for the USB transceiver, mirroring the transmit-side NRZI encoder. It samples the differential line once per recovered bit time and performs four functions: SYNC detection, NRZI decoding (no transition = 1, transition = 0), bit unstuffing and EOP detection. It delivers a stream of decoded data bits with a valid strobe to the downstream packet/byte assembler. It sits between the clock-recovery/synchronizer stage and the receive shift register.

## Interface
- SYNC_MIN_ZEROS, default 5: minimum consecutive decoded 0s before the terminating 1 for SYNC acceptance (1..7).
- ERR_IDLE_BITS, default 8: consecutive J samples that release the ERR state.
- clk  in  1  system clock.
- nRST  in  1  reset, asynchronous, active-low.
- rx_enable  in  1  0 forces IDLE and suppresses all outputs.
- bit_strobe  in  1  one-cycle pulse at bit centre, from clock recovery; all line sampling happens only on strobe cycles.
- dp, dm  in  1 each  synchronized line levels. J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
- dec_bit  out  1  decoded, unstuffed data bit.
- dec_valid  out  1  one-cycle pulse qualifying dec_bit.
- sync_found  out  1  one-cycle pulse when SYNC is accepted.
- eop_found  out  1  one-cycle pulse on a valid EOP.
- stuff_err  out  1  one-cycle pulse on a bit-stuff violation or illegal line state.
- rx_active  out  1  high from SYNC acceptance until EOP or error.

## Operation
- Reset / rx_enable=0 behaviour:
  - All outputs are 0; state is IDLE.
  - prev_line = J; ones_cnt = 0; zero_cnt = 0.
- Decode rule, evaluated on each strobe with a J or K sample: bit = (line == prev_line) ? 1 : 0. prev_line is then updated to the sample.
- IDLE:
  - J: stay.
  - K: decode (gives 0), set zero_cnt = 1, go to SYNC.
  - SE0 or SE1: stay; no error reported.
- SYNC:
  - Decoded 0: zero_cnt++, saturating at 7.
  - Decoded 1 with zero_cnt >= SYNC_MIN_ZEROS: pulse sync_found, set rx_active, set ones_cnt = 1 (the SYNC's final 1 counts toward stuffing), go to DATA.
  - Decoded 1 with zero_cnt below the minimum: return to IDLE silently.
  - SE0 or SE1: return to IDLE silently.
- DATA:
  - SE0: set se0_cnt = 1, go to EOP. No data is emitted for this sample.
  - SE1: pulse stuff_err, go to ERR.
  - ones_cnt == 6 and decoded 0: stuffed bit; drop it (no dec_valid), set ones_cnt = 0.
  - ones_cnt == 6 and decoded 1: pulse stuff_err, go to ERR.
  - Otherwise: emit dec_bit/dec_valid. ones_cnt = bit ? ones_cnt+1 : 0 (3-bit counter, never exceeds 6).
- EOP:
  - SE0: se0_cnt++. If se0_cnt would exceed 3, pulse stuff_err and go to ERR.
  - J: pulse eop_found, clear rx_active, set prev_line = J, go to IDLE.
  - K or SE1: pulse stuff_err, go to ERR.
- ERR:
  - rx_active = 0.
  - Each J strobe increments idle_cnt; any other sample clears it.
  - idle_cnt reaching ERR_IDLE_BITS returns to IDLE.
  - A J immediately after an SE0 also returns to IDLE immediately.
  - No eop_found is reported in ERR.

## Timing
- All outputs are registered. Every pulse appears in the clk cycle after the strobe cycle that caused it and lasts exactly one cycle.
- rx_active:
  - rises in the same cycle as sync_found;
  - falls in the same cycle as eop_found or stuff_err.
- Mutual exclusion: dec_valid, sync_found, eop_found and stuff_err never assert together.
- Non-strobe cycles hold all state and drive pulses to 0.
- rx_enable deassertion mid-packet: on the next clk, state is IDLE and outputs are 0; no eop_found or stuff_err is generated.
- nRST takes effect asynchronously at any time, with the same result.
- bit_strobe on consecutive clk cycles is legal: each strobe is processed.

## Structure
- Shared package usb_pkg holds:
  - line_state_t enum {J, K, SE0, SE1} and its classifier function from (dp, dm);
  - rx_state_t enum {IDLE, SYNC, DATA, EOP, ERR};
  - constant STUFF_LIMIT = 6.
- One natural sub-module: bit_unstuffer. It contains ones_cnt and produces the drop and violation flags; its ones_cnt is loaded to 1 on SYNC acceptance.
- The FSM, NRZI compare and EOP/ERR counters remain in nrzi_decoder.

## Test plan
- Full SYNC: J idle, then KJKJKJKK, then line pattern encoding data 10100101 -> one sync_found, 8 dec_valid pulses carrying 1,0,1,0,0,1,0,1; rx_active high throughout.
- Truncated SYNC of 4 zeros then 1 (SYNC_MIN_ZEROS=5) -> no sync_found; decoder back in IDLE; a following full SYNC is accepted.
- Six data 1s followed by a stuffed 0 -> six dec_valid 1s; stuffed bit dropped; the next data bit is emitted normally. Case with five data 1s after SYNC (ones_cnt starts at 1) -> stuffed bit dropped after the fifth data 1.
- Seven consecutive 1s in DATA -> stuff_err pulse on the seventh; rx_active falls; after 8 J strobes the decoder returns to IDLE.
- EOP of SE0, SE0, J -> eop_found one cycle after the J strobe; rx_active=0. Also cover: SE0 x4 -> stuff_err; SE0 then K -> stuff_err.
- Mid-packet events -> no pulses on the following cycle, all outputs 0. Cover both rx_enable deassertion and nRST assertion. Also cover strobes on back-to-back clk cycles -> every bit is decoded.
